spi_responder: RTL and testbench



---
 rtl/gigatron_spi_pkg.sv | 28 ++
 rtl/spi_sync_edge.sv | 38 +++
 rtl/spi_responder.sv | 148 ++++++++++++++
 tb/tb_spi_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gigatron_spi_pkg.sv
// Shared definitions for the Gigatron SPI responder: default parameters,
// responder state encoding and the SPI edge classifier.
package gigatron_spi_pkg;

  localparam logic [7:0] SPI_FILL_DEFAULT = 8'hFF;
  localparam int         SPI_SYNC_DEFAULT = 2;

  typedef struct packed {
    logic lead;
    logic trail;
  } spi_edge_t;

  typedef enum logic [1:0] {
    ST_LOCKOUT,
    ST_IDLE,
    ST_SEL
  } spi_state_t;

  // Leading edge leaves the idle level, trailing edge returns to it.
  function automatic spi_edge_t spi_edges(input logic prev, input logic cur,
                                          input logic idle);
    spi_edge_t e;
    e.lead  = (prev == idle) && (cur != idle);
    e.trail = (prev != idle) && (cur == idle);
    return e;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for one asynchronous SPI pin, plus leading/trailing
// edge strobes relative to the pin's idle level.
module spi_sync_edge
  import gigatron_spi_pkg::*;
#(
  parameter int   STAGES = SPI_SYNC_DEFAULT,
  parameter logic IDLE   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_lead,
  output logic o_trail
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  spi_edge_t         w_edge;

  // NOTE: the synchronizer chain is deliberately left unreset so that after
  // reset it still reflects the real pin; only the edge history is reset.
  always_ff @(posedge i_clk) begin
    r_sync[0] <= i_pin;
    for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev <= IDLE;
    else       r_prev <= r_sync[STAGES-1];
  end

  assign o_level = r_sync[STAGES-1];
  assign w_edge  = spi_edges(r_prev, o_level, IDLE);
  assign o_lead  = w_edge.lead;
  assign o_trail = w_edge.trail;

endmodule

// File: rtl/spi_responder.sv
// SPI mode CPOL/CPHA=0 target for the Gigatron bit-banged master: oversampled
// pins in the CLK domain, byte-wide valid/ready RX and TX streams.
module spi_responder
  import gigatron_spi_pkg::*;
#(
  parameter logic       CPOL        = 1'b0,
  parameter logic [7:0] FILL        = SPI_FILL_DEFAULT,
  parameter int         SYNC_STAGES = SPI_SYNC_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCK,
  input  logic       MOSI,
  input  logic       nSS,
  output logic       MISO,
  output logic       MISO_OE,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       RX_OVR,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX_UNDR
);

  logic w_sck_lead, w_sck_trail, w_unused_sck_level;
  logic w_nss_s, w_nss_lead, w_nss_trail;
  logic w_mosi_s, w_unused_mosi_lead, w_unused_mosi_trail;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(CPOL)) u_sync_sck (
    .i_clk(CLK), .i_rst(RST), .i_pin(SCK),
    .o_level(w_unused_sck_level), .o_lead(w_sck_lead), .o_trail(w_sck_trail)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_sync_nss (
    .i_clk(CLK), .i_rst(RST), .i_pin(nSS),
    .o_level(w_nss_s), .o_lead(w_nss_lead), .o_trail(w_nss_trail)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sync_mosi (
    .i_clk(CLK), .i_rst(RST), .i_pin(MOSI),
    .o_level(w_mosi_s), .o_lead(w_unused_mosi_lead), .o_trail(w_unused_mosi_trail)
  );

  spi_state_t r_state, w_state_next;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_shift, r_rx_data, r_tx_shift, r_hold;
  logic       r_rx_valid, r_rx_ovr, r_hold_full, r_tx_undr;
  logic       w_select, w_deselect, w_shift_in, w_shift_out, w_load;
  logic [7:0] w_rx_byte;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_LOCKOUT;
    else     r_state <= w_state_next;
  end

  // LOCKOUT keeps a select that was already low at reset from being taken.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      ST_LOCKOUT: if (w_nss_s)     w_state_next = ST_IDLE;
      ST_IDLE:    if (w_nss_lead)  w_state_next = ST_SEL;
      ST_SEL:     if (w_nss_trail) w_state_next = ST_IDLE;
      default:                     w_state_next = ST_LOCKOUT;
    endcase
  end

  always_comb begin
    w_select    = (r_state == ST_IDLE) && w_nss_lead;
    w_deselect  = (r_state == ST_SEL) && w_nss_trail;
    w_shift_in  = (r_state == ST_SEL) && !w_nss_trail && w_sck_lead;
    w_shift_out = (r_state == ST_SEL) && !w_nss_trail && w_sck_trail;
    w_load      = w_select || (w_shift_out && (r_bit_cnt == 3'd0));
    MISO_OE     = (r_state == ST_SEL);
    MISO        = MISO_OE ? r_tx_shift[7] : 1'b1;
  end

  assign w_rx_byte = {r_rx_shift[6:0], w_mosi_s};

  // Receive path: shift on leading edges, hand off on the eighth.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end else begin
      r_rx_ovr <= 1'b0;
      if (r_rx_valid && RX_READY) r_rx_valid <= 1'b0;
      if (w_deselect) begin
        r_bit_cnt  <= 3'd0;
        r_rx_shift <= 8'h00;
      end else if (w_select) begin
        r_bit_cnt <= 3'd0;
      end else if (w_shift_in) begin
        r_rx_shift <= w_rx_byte;
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          if (!r_rx_valid || RX_READY) begin
            r_rx_data  <= w_rx_byte;
            r_rx_valid <= 1'b1;
          end else begin
            r_rx_ovr <= 1'b1;
          end
        end
      end
    end
  end

  // Transmit path: a load sees the holding register as it was before any
  // write in the same cycle, so a racing write lands in holding instead.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tx_shift  <= 8'h00;
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
      r_tx_undr   <= 1'b0;
    end else begin
      r_tx_undr <= 1'b0;
      if (w_load) begin
        if (r_hold_full) begin
          r_tx_shift  <= r_hold;
          r_hold_full <= 1'b0;
        end else begin
          r_tx_shift <= FILL;
          r_tx_undr  <= 1'b1;
        end
      end else if (w_shift_out) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
      if (TX_VALID && !r_hold_full) begin
        r_hold      <= TX_DATA;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign RX_DATA  = r_rx_data;
  assign RX_VALID = r_rx_valid;
  assign RX_OVR   = r_rx_ovr;
  assign TX_READY = !r_hold_full;
  assign TX_UNDR  = r_tx_undr;

endmodule

// File: tb/tb_spi_responder.sv
// Scoreboard bench for spi_responder: three instances (default, FILL=00,
// CPOL=1) driven by a software-style SPI master with 4 CLK per SCK phase.
module tb_spi_responder;

  typedef struct packed {
    logic [1:0] inst;
    logic [7:0] data;
  } exp_t;

  localparam logic [2:0] CPOL_OF = 3'b100;

  logic       clk = 1'b0;
  logic       rst;
  logic       mosi;
  logic [7:0] tx_data;
  logic [2:0] sck, nss, rx_ready, tx_valid;
  logic [2:0] miso, miso_oe, rx_valid, rx_ovr, tx_ready, tx_undr;
  logic [7:0] rx_data [3];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   undr_cnt [3];
  int   ovr_cnt  [3];
  exp_t exp_rx[$];
  exp_t exp_miso[$];
  event miso_ev;
  logic [1:0] got_inst;
  logic [7:0] got_miso;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    spi_responder #(
      .CPOL(CPOL_OF[g]), .FILL((g == 1) ? 8'h00 : 8'hFF), .SYNC_STAGES(2)
    ) u_dut (
      .CLK(clk), .RST(rst), .SCK(sck[g]), .MOSI(mosi), .nSS(nss[g]),
      .MISO(miso[g]), .MISO_OE(miso_oe[g]),
      .RX_DATA(rx_data[g]), .RX_VALID(rx_valid[g]), .RX_READY(rx_ready[g]),
      .RX_OVR(rx_ovr[g]), .TX_DATA(tx_data), .TX_VALID(tx_valid[g]),
      .TX_READY(tx_ready[g]), .TX_UNDR(tx_undr[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // RX monitor and pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (tx_undr[k]) undr_cnt[k]++;
      if (rx_ovr[k])  ovr_cnt[k]++;
      if (!rst && rx_valid[k] && rx_ready[k]) begin
        exp_t e;
        if (exp_rx.size() == 0) begin
          check("rx_spurious_valid", rx_valid[k], 1'b0);
        end else begin
          e = exp_rx.pop_front();
          check("rx_inst", k, e.inst);
          check("rx_data", rx_data[k], e.data);
        end
      end
    end
  end

  // MISO monitor: compares each byte the master captured.
  always @(miso_ev) begin
    exp_t e;
    if (exp_miso.size() == 0) begin
      check("miso_spurious_inst", got_inst, 2'd3);
    end else begin
      e = exp_miso.pop_front();
      check("miso_inst", got_inst, e.inst);
      check("miso_byte", got_miso, e.data);
    end
  end

  task automatic push_rx(input int k, input logic [7:0] d);
    exp_rx.push_back({k[1:0], d});
  endtask

  task automatic push_miso(input int k, input logic [7:0] d);
    exp_miso.push_back({k[1:0], d});
  endtask

  task automatic tx_write(input int k, input logic [7:0] d);
    int n = 0;
    while (!tx_ready[k] && n < 50) begin
      cyc(1);
      n++;
    end
    check("tx_ready_wait", tx_ready[k], 1'b1);
    tx_data     = d;
    tx_valid[k] = 1'b1;
    cyc(1);
    tx_valid[k] = 1'b0;
  endtask

  task automatic sel(input int k);
    nss[k] = 1'b0;
    cyc(4);
  endtask

  task automatic desel(input int k);
    nss[k] = 1'b1;
    cyc(4);
  endtask

  // Master: MOSI set at the idle phase, MISO sampled just before the
  // leading edge, SCK back to idle for the trailing edge.
  task automatic xfer(input int k, input logic [7:0] b, input int nbits,
                      input bit check_lat);
    logic       idle = CPOL_OF[k];
    logic [7:0] cap  = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      cyc(4);
      cap[7-i] = miso[k];
      sck[k] = ~idle;
      if (check_lat && i == 7) begin
        cyc(2);
        check("rx_valid_lat2", rx_valid[k], 1'b0);
        cyc(1);
        check("rx_valid_lat3", rx_valid[k], 1'b1);
        cyc(1);
      end else begin
        cyc(4);
      end
      sck[k] = idle;
    end
    cyc(4);
    if (nbits == 8) begin
      got_inst = k[1:0];
      got_miso = cap;
      -> miso_ev;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int u0, o0;
    for (int k = 0; k < 3; k++) begin
      undr_cnt[k] = 0;
      ovr_cnt[k]  = 0;
    end
    rst = 1'b1; mosi = 1'b0; tx_data = 8'h00;
    sck = CPOL_OF; nss = 3'b111; rx_ready = 3'b111; tx_valid = 3'b000;
    cyc(3);
    for (int k = 0; k < 3; k++) begin
      check("rst_miso",     miso[k],     1'b1);
      check("rst_miso_oe",  miso_oe[k],  1'b0);
      check("rst_rx_data",  rx_data[k],  8'h00);
      check("rst_rx_valid", rx_valid[k], 1'b0);
      check("rst_rx_ovr",   rx_ovr[k],   1'b0);
      check("rst_tx_ready", tx_ready[k], 1'b1);
      check("rst_tx_undr",  tx_undr[k],  1'b0);
    end
    rst = 1'b0;
    cyc(4);

    // Preloaded 3C out, A5 in, with RX_VALID latency.
    tx_write(0, 8'h3C);
    push_miso(0, 8'h3C);
    push_rx(0, 8'hA5);
    sel(0);
    check("sel_miso_oe", miso_oe[0], 1'b1);
    xfer(0, 8'hA5, 8, 1'b1);
    desel(0);

    // Overrun: RX_READY held low across two bytes.
    rx_ready[0] = 1'b0;
    o0 = ovr_cnt[0];
    push_miso(0, 8'hFF);
    push_miso(0, 8'hFF);
    sel(0);
    xfer(0, 8'h01, 8, 1'b0);
    xfer(0, 8'h02, 8, 1'b0);
    desel(0);
    check("ovr_pulse_cycles", ovr_cnt[0] - o0, 1);
    check("ovr_keeps_first", rx_data[0], 8'h01);
    check("ovr_valid_held", rx_valid[0], 1'b1);
    push_rx(0, 8'h01);
    rx_ready[0] = 1'b1;
    cyc(2);

    // Underrun fill, both FILL values.
    u0 = undr_cnt[0];
    sel(0);
    check("undr_at_select", undr_cnt[0] - u0, 1);
    push_miso(0, 8'hFF);
    push_rx(0, 8'h00);
    xfer(0, 8'h00, 8, 1'b0);
    desel(0);
    u0 = undr_cnt[1];
    sel(1);
    check("undr_at_select_f0", undr_cnt[1] - u0, 1);
    push_miso(1, 8'h00);
    push_rx(1, 8'h3A);
    xfer(1, 8'h3A, 8, 1'b0);
    desel(1);

    // Aborted partial byte, then a full one.
    sel(0);
    xfer(0, 8'hF0, 5, 1'b0);
    desel(0);
    check("abort_no_valid", rx_valid[0], 1'b0);
    check("desel_miso_oe", miso_oe[0], 1'b0);
    check("desel_miso", miso[0], 1'b1);
    push_miso(0, 8'hFF);
    push_rx(0, 8'h81);
    sel(0);
    xfer(0, 8'h81, 8, 1'b0);
    desel(0);
    check("after_abort_rx_data", rx_data[0], 8'h81);

    // TX write in the same CLK as the select-triggered load.
    nss[0] = 1'b0;
    cyc(2);
    tx_data = 8'h55;
    tx_valid[0] = 1'b1;
    cyc(1);
    tx_valid[0] = 1'b0;
    check("race_hold_full", tx_ready[0], 1'b0);
    push_miso(0, 8'hFF);
    push_miso(0, 8'h55);
    push_rx(0, 8'h96);
    push_rx(0, 8'h69);
    xfer(0, 8'h96, 8, 1'b0);
    xfer(0, 8'h69, 8, 1'b0);
    desel(0);

    // CPOL=1, idle-high SCK.
    push_miso(2, 8'hFF);
    push_rx(2, 8'hC3);
    sel(2);
    xfer(2, 8'hC3, 8, 1'b0);
    desel(2);

    // Reset mid-byte with holding full; the open select must stay ignored.
    tx_write(0, 8'h3C);
    sel(0);
    tx_write(0, 8'h77);
    xfer(0, 8'hE1, 4, 1'b0);
    check("pre_rst_tx_ready", tx_ready[0], 1'b0);
    rst = 1'b1;
    cyc(1);
    check("mid_rst_miso",     miso[0],     1'b1);
    check("mid_rst_miso_oe",  miso_oe[0],  1'b0);
    check("mid_rst_rx_data",  rx_data[0],  8'h00);
    check("mid_rst_rx_valid", rx_valid[0], 1'b0);
    check("mid_rst_rx_ovr",   rx_ovr[0],   1'b0);
    check("mid_rst_tx_ready", tx_ready[0], 1'b1);
    check("mid_rst_tx_undr",  tx_undr[0],  1'b0);
    rst = 1'b0;
    push_miso(0, 8'hFF);
    xfer(0, 8'h00, 8, 1'b0);
    check("lockout_miso_oe", miso_oe[0], 1'b0);
    check("lockout_rx_valid", rx_valid[0], 1'b0);
    desel(0);
    push_miso(0, 8'hFF);
    push_rx(0, 8'h5A);
    sel(0);
    xfer(0, 8'h5A, 8, 1'b0);
    desel(0);

    cyc(10);
    check("rx_queue_empty", exp_rx.size(), 0);
    check("miso_queue_empty", exp_miso.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
